lvds_rx_phase_ctrl: RTL

Phase-alignment controller for the LVDS 7:1 receive PLL. It resets the PLL and waits for lock. It then sweeps the PLL dynamic phase (`psda`) across all 16 steps while checking the deserialized clock-lane word against the training pattern, and programs the centre of the widest passing window. It sits between the LVDS RX PLL wrapper (drives its `reset`/`psda`/`dutyda`/`fdly`, reads `lock`) and the deserializer output, in the parallel-word clock domain.

---
 rtl/lvds_rx_phase_ctrl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/lvds_rx_phase_ctrl.sv
// LVDS 7:1 RX phase alignment: reset PLL, wait for lock, sweep psda over 16 steps
// against the clock-lane training word, then program the centre of the widest window.
// state     | meaning
// RST_PLL   | hold PLL in reset
// WAIT_LOCK | wait for stable synchronized lock
// SETTLE    | let the new psda settle
// CHECK     | compare valid words to training pattern
// NEXT      | advance phase or finish sweep
// SCAN      | two laps over pass map for widest window
// APPLY     | program centre or count a failed attempt
// DONE      | aligned, psda held
// FAIL      | retries exhausted
module lvds_rx_phase_ctrl #(
  parameter int         RST_CYCLES    = 16,
  parameter int         LOCK_CYCLES   = 1024,
  parameter int         SETTLE_CYCLES = 64,
  parameter int         CHECK_CYCLES  = 256,
  parameter int         MAX_RETRY     = 3,
  parameter logic [6:0] TRAIN_PATTERN = 7'b1100011,
  parameter logic [3:0] DUTYDA_VAL    = 4'b1000,
  parameter logic [3:0] FDLY_VAL      = 4'b0000
) (
  input  logic        clkin,
  input  logic        reset,
  input  logic        pll_lock,
  input  logic [6:0]  rx_word,
  input  logic        rx_valid,
  input  logic        realign,
  output logic        pll_reset,
  output logic [3:0]  psda,
  output logic [3:0]  dutyda,
  output logic [3:0]  fdly,
  output logic        align_done,
  output logic        align_fail,
  output logic [15:0] pass_map,
  output logic [4:0]  best_len
);

  localparam int MAX_A = (RST_CYCLES > LOCK_CYCLES) ? RST_CYCLES : LOCK_CYCLES;
  localparam int MAX_B = (SETTLE_CYCLES > CHECK_CYCLES) ? SETTLE_CYCLES : CHECK_CYCLES;
  localparam int MAXC  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int TW    = $clog2(MAXC + 1);
  localparam int RW    = $clog2(MAX_RETRY + 1);

  localparam logic [TW-1:0] RST_LOAD    = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LOAD   = TW'(LOCK_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] CHECK_LOAD  = TW'(CHECK_CYCLES - 1);

  typedef enum logic [3:0] {
    RST_PLL, WAIT_LOCK, SETTLE, CHECK, NEXT, SCAN, APPLY, DONE, FAIL
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [3:0]    idx;
  logic [15:0]   work_map;
  logic          seen, bad;
  logic [4:0]    scan_i, run, best;
  logic [3:0]    best_end;
  logic [RW-1:0] retry;
  logic          lock_s1, lock_s2;

  logic          word_ok, phase_pass, lock_lost, sweeping, attempt_fail;
  logic          retry_left, go_rst;
  logic [4:0]    run_nxt;
  logic [RW-1:0] retry_inc;

  assign dutyda = DUTYDA_VAL;
  assign fdly   = FDLY_VAL;

  assign word_ok    = (rx_word == TRAIN_PATTERN);
  // the last CHECK cycle's word counts toward the verdict
  assign phase_pass = (seen | rx_valid) & ~(bad | (rx_valid & ~word_ok));
  assign run_nxt    = pass_map[scan_i[3:0]] ? ((run == 5'd16) ? 5'd16 : run + 5'd1) : 5'd0;
  assign lock_lost  = ~lock_s2;
  assign sweeping   = (state == SETTLE) || (state == CHECK) || (state == NEXT) || (state == SCAN);
  assign attempt_fail = (sweeping && lock_lost) || (state == APPLY && best == 5'd0);
  assign retry_inc  = retry + RW'(1);
  assign retry_left = (int'(retry_inc) < MAX_RETRY);
  assign go_rst     = realign || (attempt_fail && retry_left) || (state == DONE && lock_lost);

  always_ff @(posedge clkin) begin
    if (reset) begin
      state      <= RST_PLL;
      timer      <= RST_LOAD;
      pll_reset  <= 1'b1;
      psda       <= 4'd0;
      idx        <= 4'd0;
      align_done <= 1'b0;
      align_fail <= 1'b0;
      pass_map   <= 16'd0;
      best_len   <= 5'd0;
      retry      <= '0;
      work_map   <= 16'd0;
      seen       <= 1'b0;
      bad        <= 1'b0;
      scan_i     <= 5'd0;
      run        <= 5'd0;
      best       <= 5'd0;
      best_end   <= 4'd0;
      lock_s1    <= 1'b0;
      lock_s2    <= 1'b0;
    end else begin
      lock_s1 <= pll_lock;
      lock_s2 <= lock_s1;
      if (go_rst) begin
        state      <= RST_PLL;
        timer      <= RST_LOAD;
        pll_reset  <= 1'b1;
        psda       <= 4'd0;
        idx        <= 4'd0;
        align_done <= 1'b0;
        align_fail <= 1'b0;
        retry      <= (realign || !attempt_fail) ? '0 : retry_inc;
      end else if (attempt_fail) begin
        state      <= FAIL;
        retry      <= retry_inc;
        align_fail <= 1'b1;
        align_done <= 1'b0;
        psda       <= 4'd0;
      end else begin
        case (state)
          RST_PLL: begin
            if (timer == '0) begin
              pll_reset <= 1'b0;
              timer     <= LOCK_LOAD;
              state     <= WAIT_LOCK;
            end else begin
              timer <= timer - TW'(1);
            end
          end
          WAIT_LOCK: begin
            if (lock_lost) begin
              timer <= LOCK_LOAD;
            end else if (timer == '0) begin
              work_map <= 16'd0;
              psda     <= idx;
              timer    <= SETTLE_LOAD;
              state    <= SETTLE;
            end else begin
              timer <= timer - TW'(1);
            end
          end
          SETTLE: begin
            if (timer == '0) begin
              seen  <= 1'b0;
              bad   <= 1'b0;
              timer <= CHECK_LOAD;
              state <= CHECK;
            end else begin
              timer <= timer - TW'(1);
            end
          end
          CHECK: begin
            if (rx_valid) begin
              seen <= 1'b1;
              if (!word_ok) bad <= 1'b1;
            end
            if (timer == '0) begin
              work_map[idx] <= phase_pass;
              state         <= NEXT;
            end else begin
              timer <= timer - TW'(1);
            end
          end
          NEXT: begin
            if (idx == 4'd15) begin
              pass_map <= work_map;
              scan_i   <= 5'd0;
              run      <= 5'd0;
              best     <= 5'd0;
              best_end <= 4'd0;
              state    <= SCAN;
            end else begin
              idx   <= idx + 4'd1;
              psda  <= idx + 4'd1;
              timer <= SETTLE_LOAD;
              state <= SETTLE;
            end
          end
          SCAN: begin
            // second lap lets windows that wrap past phase 15 accumulate
            run <= run_nxt;
            if (run_nxt > best) begin
              best     <= run_nxt;
              best_end <= scan_i[3:0];
            end
            scan_i <= scan_i + 5'd1;
            if (scan_i == 5'd31) state <= APPLY;
          end
          APPLY: begin
            psda       <= best_end - best[4:1];
            best_len   <= best;
            align_done <= 1'b1;
            state      <= DONE;
          end
          DONE: ;
          FAIL: ;
          default: state <= RST_PLL;
        endcase
      end
    end
  end

endmodule
